// File: rtl/fft_frame_streamer.sv
// Snapshots a 16-deep sample history every HOP strobes and streams it oldest-first over valid/ready.
// Optional Hann windowing stage enabled by defining FFT_FRAME_WINDOW_EN.
module fft_frame_streamer #(
  parameter int HOP = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_t,
  input  logic signed [17:0] t0,
  input  logic signed [17:0] t1,
  input  logic signed [17:0] t2,
  input  logic signed [17:0] t3,
  input  logic signed [17:0] t4,
  input  logic signed [17:0] t5,
  input  logic signed [17:0] t6,
  input  logic signed [17:0] t7,
  input  logic signed [17:0] t8,
  input  logic signed [17:0] t9,
  input  logic signed [17:0] t10,
  input  logic signed [17:0] t11,
  input  logic signed [17:0] t12,
  input  logic signed [17:0] t13,
  input  logic signed [17:0] t14,
  input  logic signed [17:0] t15,
  input  logic               src_ready,
  output logic               src_valid,
  output logic signed [17:0] src_data,
  output logic               src_sop,
  output logic               src_eop,
  output logic               overrun,
  output logic [7:0]         drop_cnt
);

  localparam int DATA_W = 18;
  localparam logic [7:0] HOP_LAST = 8'(HOP - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    state;
  logic [7:0]                hop_cnt;
  logic [3:0]                idx;
  logic [3:0]                idx_nxt;
  logic signed [DATA_W-1:0]  frame [16];
  logic                      trigger;
  logic                      take;
  logic                      xfer_p0;

  logic                      vld_p0;
  logic                      sop_p0;
  logic                      eop_p0;
  logic signed [DATA_W-1:0]  data_p0;

  assign trigger = new_t && (hop_cnt == HOP_LAST);
  assign idx_nxt = idx + 4'd1;
  assign xfer_p0 = vld_p0 && take;

  // Snapshot buffer is only written from IDLE, so a dropped frame never disturbs it.
  always_ff @(posedge clk) begin
    if (state == IDLE && trigger) begin
      frame <= '{t15, t14, t13, t12, t11, t10, t9, t8,
                 t7,  t6,  t5,  t4,  t3,  t2,  t1, t0};
    end
  end

  // Stage p0: frame sequencer and drop bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hop_cnt  <= '0;
      idx      <= '0;
      vld_p0   <= 1'b0;
      sop_p0   <= 1'b0;
      eop_p0   <= 1'b0;
      data_p0  <= '0;
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (new_t) begin
        hop_cnt <= trigger ? 8'd0 : hop_cnt + 8'd1;
      end
      if (trigger && state == STREAM) begin
        overrun <= 1'b1;
        if (drop_cnt != 8'd255) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state   <= STREAM;
            idx     <= '0;
            vld_p0  <= 1'b1;
            sop_p0  <= 1'b1;
            eop_p0  <= 1'b0;
            data_p0 <= t15;
          end
        end
        STREAM: begin
          if (xfer_p0) begin
            if (idx == 4'd15) begin
              state  <= IDLE;
              vld_p0 <= 1'b0;
              sop_p0 <= 1'b0;
              eop_p0 <= 1'b0;
            end else begin
              idx     <= idx_nxt;
              data_p0 <= frame[idx_nxt];
              sop_p0  <= 1'b0;
              eop_p0  <= (idx == 4'd14);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FFT_FRAME_WINDOW_EN
  localparam int COEF_W = 16;

  logic                      vld_p1;
  logic                      sop_p1;
  logic                      eop_p1;
  logic signed [DATA_W-1:0]  data_p1;

  // Periodic Hann, Q1.15, w[n] = round(32767*0.5*(1-cos(2*pi*n/16)))
  function automatic logic signed [COEF_W-1:0] hann_coef(input logic [3:0] n);
    case (n)
      4'd0:           return 16'sd0;
      4'd1,  4'd15:   return 16'sd1247;
      4'd2,  4'd14:   return 16'sd4799;
      4'd3,  4'd13:   return 16'sd10114;
      4'd4,  4'd12:   return 16'sd16384;
      4'd5,  4'd11:   return 16'sd22653;
      4'd6,  4'd10:   return 16'sd27968;
      4'd7,  4'd9:    return 16'sd31520;
      default:        return 16'sd32767;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [33:0] prod);
    logic signed [34:0] rnd;
    logic signed [19:0] q;
    rnd = 35'(prod) + 35'sd16384;
    q   = 20'(rnd >>> 15);
    if (q > 20'sd131071) begin
      return 18'sd131071;
    end else if (q < -20'sd131072) begin
      return -18'sd131072;
    end
    return q[17:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] window_sample(input logic signed [DATA_W-1:0] s,
                                                             input logic [3:0] n);
    logic signed [33:0] prod;
    prod = 34'(s) * 34'(hann_coef(n));
    return round_sat(prod);
  endfunction

  // p1 refills whenever it is empty or its beat is leaving, so both stages stall together.
  assign take = !vld_p1 || src_ready;

  // Stage p1: windowed output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (take) begin
      vld_p1  <= vld_p0;
      sop_p1  <= sop_p0;
      eop_p1  <= eop_p0;
      if (vld_p0) begin
        data_p1 <= window_sample(data_p0, idx);
      end
    end
  end

  assign src_valid = vld_p1;
  assign src_sop   = sop_p1;
  assign src_eop   = eop_p1;
  assign src_data  = data_p1;
`else
  assign take      = src_ready;
  assign src_valid = vld_p0;
  assign src_sop   = sop_p0;
  assign src_eop   = eop_p0;
  assign src_data  = data_p0;
`endif

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Directed bench for fft_frame_streamer: HOP=16 and HOP=4 instances share stimulus.
// Expected values follow FFT_FRAME_WINDOW_EN when it is defined.
module tb_fft_frame_streamer;

`ifdef FFT_FRAME_WINDOW_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               new_t;
  logic               src_ready;
  logic signed [17:0] t_in [16];

  logic               v16, s16, e16, o16;
  logic signed [17:0] d16;
  logic [7:0]         c16;
  logic               v4, s4, e4, o4;
  logic signed [17:0] d4;
  logic [7:0]         c4;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic               o_valid, o_sop, o_eop;
  logic signed [17:0] o_data;

  always_comb begin
    o_valid = v16;
    o_sop   = s16;
    o_eop   = e16;
    o_data  = d16;
    if (sel == 1) begin
      o_valid = v4;
      o_sop   = s4;
      o_eop   = e4;
      o_data  = d4;
    end
  end

  fft_frame_streamer #(.HOP(16)) u_dut16 (
    .clk(clk), .reset(reset), .new_t(new_t),
    .t0(t_in[0]), .t1(t_in[1]), .t2(t_in[2]), .t3(t_in[3]),
    .t4(t_in[4]), .t5(t_in[5]), .t6(t_in[6]), .t7(t_in[7]),
    .t8(t_in[8]), .t9(t_in[9]), .t10(t_in[10]), .t11(t_in[11]),
    .t12(t_in[12]), .t13(t_in[13]), .t14(t_in[14]), .t15(t_in[15]),
    .src_ready(src_ready), .src_valid(v16), .src_data(d16),
    .src_sop(s16), .src_eop(e16), .overrun(o16), .drop_cnt(c16)
  );

  fft_frame_streamer #(.HOP(4)) u_dut4 (
    .clk(clk), .reset(reset), .new_t(new_t),
    .t0(t_in[0]), .t1(t_in[1]), .t2(t_in[2]), .t3(t_in[3]),
    .t4(t_in[4]), .t5(t_in[5]), .t6(t_in[6]), .t7(t_in[7]),
    .t8(t_in[8]), .t9(t_in[9]), .t10(t_in[10]), .t11(t_in[11]),
    .t12(t_in[12]), .t13(t_in[13]), .t14(t_in[14]), .t15(t_in[15]),
    .src_ready(src_ready), .src_valid(v4), .src_data(d4),
    .src_sop(s4), .src_eop(e4), .overrun(o4), .drop_cnt(c4)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int n);
    new_t = 1'b1;
    repeat (n) tick();
    new_t = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reference model of one output sample at frame position n.
  function automatic logic signed [17:0] model(input int s, input int n);
`ifdef FFT_FRAME_WINDOW_EN
    int w [16] = '{0, 1247, 4799, 10114, 16384, 22653, 27968, 31520,
                   32767, 31520, 27968, 22653, 16384, 10114, 4799, 1247};
    longint p;
    p = (longint'(s) * longint'(w[n]) + 64'sd16384) >>> 15;
    if (p > 131071) p = 131071;
    if (p < -131072) p = -131072;
    return 18'(p);
`else
    return 18'(s);
`endif
  endfunction

  task automatic get_frame(input logic signed [17:0] exp [16], input bit toggle,
                           output int lat, output int span);
    int beats = 0;
    int cyc = 0;
    int waitc = 0;
    lat = 0;
    span = 0;
    while (!o_valid && waitc < 10) begin
      tick();
      waitc++;
    end
    lat = waitc + 1;
    check("frame_start", o_valid, 1);
    while (beats < 16 && cyc < 64) begin
      src_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      check($sformatf("valid%0d", beats), o_valid, 1);
      check($sformatf("data%0d", beats), o_data, exp[beats]);
      check($sformatf("sop%0d", beats), o_sop, beats == 0);
      check($sformatf("eop%0d", beats), o_eop, beats == 15);
      if (src_ready) beats++;
      tick();
      cyc++;
    end
    span = cyc;
    check("beat_count", beats, 16);
    check("valid_after_frame", o_valid, 0);
    src_ready = 1'b1;
  endtask

  logic signed [17:0] exp_f [16];
  logic signed [17:0] hann_ref [16];
  int lat, span;

  initial begin
    reset = 1'b1;
    new_t = 1'b0;
    src_ready = 1'b1;
    for (int k = 0; k < 16; k++) t_in[k] = '0;
    repeat (2) tick();

    check("rst_valid16", v16, 0);
    check("rst_data16", d16, 0);
    check("rst_sop16", s16, 0);
    check("rst_eop16", e16, 0);
    check("rst_overrun16", o16, 0);
    check("rst_drop16", c16, 0);
    check("rst_valid4", v4, 0);
    check("rst_data4", d4, 0);
    check("rst_overrun4", o4, 0);
    check("rst_drop4", c4, 0);
    reset = 1'b0;
    tick();

    // Basic frame, ready held high
    sel = 0;
    for (int k = 0; k < 16; k++) t_in[k] = 18'(k + 1);
    for (int j = 0; j < 16; j++) exp_f[j] = model(16 - j, j);
    strobe(16);
    get_frame(exp_f, 1'b0, lat, span);
    check("latency_basic", lat, LAT);
    check("span_basic", span, 16);
    check("overrun_basic", o16, 0);
    check("drop_basic", c16, 0);

    // Ready toggling 1,0,1,0 stretches the frame to 31 cycles
    strobe(16);
    get_frame(exp_f, 1'b1, lat, span);
    check("latency_toggle", lat, LAT);
    check("span_toggle", span, 31);

    // HOP=4 with the sink stalled: second trigger is dropped, first frame intact
    pulse_reset();
    sel = 1;
    src_ready = 1'b0;
    for (int k = 0; k < 16; k++) t_in[k] = 18'(100 + k);
    strobe(4);
    repeat (2) tick();
    check("stall_valid", o_valid, 1);
    check("stall_data", o_data, model(115, 0));
    check("stall_sop", o_sop, 1);
    for (int k = 0; k < 16; k++) t_in[k] = 18'(200 + k);
    strobe(4);
    check("drop_overrun", o4, 1);
    check("drop_cnt1", c4, 1);
    for (int j = 0; j < 16; j++) exp_f[j] = model(115 - j, j);
    get_frame(exp_f, 1'b0, lat, span);
    check("drop_cnt_hold", c4, 1);

    // Reset asserted at beat 7 clears outputs at once, next trigger is a clean frame
    pulse_reset();
    sel = 0;
    src_ready = 1'b1;
    for (int k = 0; k < 16; k++) t_in[k] = 18'(k + 1);
    strobe(16);
    repeat (LAT - 1 + 7) tick();
    check("beat7_valid", v16, 1);
    check("beat7_data", d16, model(9, 7));
    reset = 1'b1;
    #1;
    check("midrst_valid", v16, 0);
    check("midrst_data", d16, 0);
    check("midrst_sop", s16, 0);
    check("midrst_eop", e16, 0);
    reset = 1'b0;
    tick();
    check("postrst_valid", v16, 0);
    for (int j = 0; j < 16; j++) exp_f[j] = model(16 - j, j);
    strobe(16);
    get_frame(exp_f, 1'b0, lat, span);
    check("latency_postrst", lat, LAT);

    // Full-scale positive samples against hand-computed window outputs
    hann_ref = '{18'sd0, 18'sd4988, 18'sd19196, 18'sd40456, 18'sd65536, 18'sd90611,
                 18'sd111871, 18'sd126079, 18'sd131067, 18'sd126079, 18'sd111871,
                 18'sd90611, 18'sd65536, 18'sd40456, 18'sd19196, 18'sd4988};
    for (int k = 0; k < 16; k++) t_in[k] = 18'sd131071;
    for (int j = 0; j < 16; j++) begin
`ifdef FFT_FRAME_WINDOW_EN
      exp_f[j] = hann_ref[j];
`else
      exp_f[j] = 18'sd131071;
`endif
    end
    strobe(16);
    get_frame(exp_f, 1'b0, lat, span);
    check("latency_fullscale", lat, LAT);

    // 300 forced drops saturate the counter
    pulse_reset();
    sel = 1;
    src_ready = 1'b0;
    strobe(4);
    strobe(40);
    check("drop_cnt10", c4, 10);
    strobe(1160);
    check("drop_cnt_sat", c4, 255);
    check("overrun_sat", o4, 1);
    src_ready = 1'b1;
    repeat (40) tick();
    check("drained_valid", v4, 0);
    check("drop_cnt_kept", c4, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
